// File: rtl/sym_ib_pkg.sv
// Shared definitions for the symmetric IB LUT loaders and LUT output blocks.
package sym_ib_pkg;

  localparam int unsigned DEF_PAGE_NUM = 64;
  localparam int unsigned DEF_ADDR_W   = 6;
  localparam int unsigned LUT_W        = 4;
  localparam int unsigned DEF_PIPE_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LOADED = 3'd2,
    ST_SWAP   = 3'd3,
    ST_DRAIN  = 3'd4
  } ld_state_t;

  // One feeder beat: a page pair, bank1 in the upper nibble.
  typedef struct packed {
    logic [LUT_W-1:0] bank1;
    logic [LUT_W-1:0] bank0;
  } lut_beat_t;

endpackage

// File: rtl/sym_lut_drain_cnt.sv
// Loadable down-counter: holds 'hold' high from the load until it reaches zero,
// then drops 'hold' and pulses 'done' for one cycle. load_val must be >= 1.
module sym_lut_drain_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             hold,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Count down while holding; the 1->0 step ends the hold and fires done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      hold <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      hold <= 1'b1;
      done <= 1'b0;
    end else if (hold) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        hold <= 1'b0;
        done <= 1'b1;
      end else begin
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/sym_vn_lut_loader.sv
// VN LUT write-port and ping-pong page-offset controller.
module sym_vn_lut_loader
  import sym_ib_pkg::*;
#(
  parameter int unsigned PAGE_NUM = DEF_PAGE_NUM,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  output logic              load_done,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              rd_hold,
  output logic              read_addr_offset,
  output logic [LUT_W-1:0]  lut_in_bank0,
  output logic [LUT_W-1:0]  lut_in_bank1,
  output logic [ADDR_W-1:0] page_write_addr,
  output logic              write_addr_offset,
  output logic              we
);

  localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(PAGE_NUM - 1);
  // Loaded on entry to SWAP so the counter reads PIPE_LAT on the first DRAIN cycle.
  localparam int unsigned        DRAIN_W    = $clog2(PIPE_LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT + 1);

  ld_state_t         state, state_nxt;
  logic [ADDR_W-1:0] page_cnt, page_cnt_nxt;
  logic              loaded, loaded_nxt;
  logic              ld_ready_nxt, we_nxt, load_done_nxt, rd_off_nxt;
  logic [ADDR_W-1:0] page_addr_nxt;
  logic [LUT_W-1:0]  bank0_nxt, bank1_nxt;
  logic              drain_load;
  logic              accept;
  lut_beat_t         beat;

  assign beat              = lut_beat_t'(ld_data);
  assign accept            = (state == ST_LOAD) && ld_valid && ld_ready;
  assign write_addr_offset = ~read_addr_offset;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    page_cnt_nxt  = page_cnt;
    loaded_nxt    = loaded;
    we_nxt        = 1'b0;
    load_done_nxt = 1'b0;
    rd_off_nxt    = read_addr_offset;
    page_addr_nxt = page_write_addr;
    bank0_nxt     = lut_in_bank0;
    bank1_nxt     = lut_in_bank1;
    drain_load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt    = ST_LOAD;
          page_cnt_nxt = '0;
          loaded_nxt   = 1'b0;
        end else if (swap_req && loaded) begin
          state_nxt  = ST_SWAP;
          rd_off_nxt = ~read_addr_offset;
          drain_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we_nxt        = 1'b1;
          page_addr_nxt = page_cnt;
          bank0_nxt     = beat.bank0;
          bank1_nxt     = beat.bank1;
          if (page_cnt == LAST_PAGE) begin
            page_cnt_nxt  = '0;
            loaded_nxt    = 1'b1;
            load_done_nxt = 1'b1;
            state_nxt     = ST_LOADED;
          end else begin
            page_cnt_nxt = page_cnt + ADDR_W'(1);
          end
        end
      end
      ST_LOADED: begin
        // A concurrent load_start is dropped when a swap is taken.
        if (swap_req && loaded) begin
          state_nxt  = ST_SWAP;
          rd_off_nxt = ~read_addr_offset;
          drain_load = 1'b1;
        end else if (load_start) begin
          state_nxt    = ST_LOAD;
          page_cnt_nxt = '0;
          loaded_nxt   = 1'b0;
        end
      end
      ST_SWAP: begin
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (swap_ack) begin
          state_nxt  = ST_IDLE;
          loaded_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    ld_ready_nxt = (state_nxt == ST_LOAD);
  end

  // FSM state, page counter and loaded flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      page_cnt <= '0;
      loaded   <= 1'b0;
    end else begin
      state    <= state_nxt;
      page_cnt <= page_cnt_nxt;
      loaded   <= loaded_nxt;
    end
  end

  // Registered outputs toward the feeder and the LUT datapath.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ld_ready         <= 1'b0;
      we               <= 1'b0;
      load_done        <= 1'b0;
      read_addr_offset <= 1'b0;
      page_write_addr  <= '0;
      lut_in_bank0     <= '0;
      lut_in_bank1     <= '0;
    end else begin
      ld_ready         <= ld_ready_nxt;
      we               <= we_nxt;
      load_done        <= load_done_nxt;
      read_addr_offset <= rd_off_nxt;
      page_write_addr  <= page_addr_nxt;
      lut_in_bank0     <= bank0_nxt;
      lut_in_bank1     <= bank1_nxt;
    end
  end

  sym_lut_drain_cnt #(
    .CNT_W (DRAIN_W)
  ) u_drain (
    .clk      (sys_clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (DRAIN_INIT),
    .hold     (rd_hold),
    .done     (swap_ack)
  );

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench for sym_vn_lut_loader: vector table plus randomized load/swap episodes.
module tb_sym_vn_lut_loader;

  localparam int unsigned PAGES = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned PL    = 2;

  logic          sys_clk = 1'b0;
  logic          rst, load_start, ld_valid, ld_ready, load_done;
  logic [7:0]    ld_data;
  logic          swap_req, swap_ack, rd_hold, read_addr_offset, write_addr_offset, we;
  logic [3:0]    lut_in_bank0, lut_in_bank1;
  logic [AW-1:0] page_write_addr;

  sym_vn_lut_loader #(
    .PAGE_NUM (PAGES),
    .ADDR_W   (AW),
    .PIPE_LAT (PL)
  ) dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .load_start        (load_start),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_data           (ld_data),
    .load_done         (load_done),
    .swap_req          (swap_req),
    .swap_ack          (swap_ack),
    .rd_hold           (rd_hold),
    .read_addr_offset  (read_addr_offset),
    .lut_in_bank0      (lut_in_bank0),
    .lut_in_bank1      (lut_in_bank1),
    .page_write_addr   (page_write_addr),
    .write_addr_offset (write_addr_offset),
    .we                (we)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard: image of the LUT memory as the datapath would see it, plus event log.
  logic [7:0] mem_cap [2][PAGES];
  int         wr_cnt  [PAGES];
  int         wr_cyc  [PAGES];
  int         we_total, done_cnt, done_cyc, ack_cnt, ack_cyc, hold_cnt, toggle_cnt, toggle_cyc, viol;
  logic       prev_roff;
  logic       model_roff;

  typedef struct {
    logic       rst, ls, vld, swp;
    logic [7:0] data;
    logic       e_rdy, e_we, e_done, e_ack, e_hold, e_roff;
    logic [5:0] e_page;
    logic [3:0] e_b0, e_b1;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_sb();
    for (int i = 0; i < int'(PAGES); i++) begin
      mem_cap[0][i] = '0;
      mem_cap[1][i] = '0;
      wr_cnt[i]     = 0;
      wr_cyc[i]     = -1;
    end
    we_total   = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    ack_cnt    = 0;
    ack_cyc    = -1;
    hold_cnt   = 0;
    toggle_cnt = 0;
    toggle_cyc = -1;
    viol       = 0;
    prev_roff  = model_roff;
  endtask

  // Record this cycle's DUT outputs into the scoreboard.
  task automatic observe();
    if (we) begin
      mem_cap[write_addr_offset][page_write_addr] = {lut_in_bank1, lut_in_bank0};
      wr_cnt[page_write_addr]++;
      wr_cyc[page_write_addr] = cyc;
      we_total++;
      if (rd_hold) viol++;
      if (write_addr_offset == model_roff) viol++;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (!we || int'(page_write_addr) != int'(PAGES) - 1) viol++;
    end
    if (swap_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
      if (rd_hold) viol++;
    end
    if (rd_hold) hold_cnt++;
    if (read_addr_offset != prev_roff) begin
      toggle_cnt++;
      toggle_cyc = cyc;
      prev_roff  = read_addr_offset;
    end
    if (write_addr_offset == read_addr_offset) viol++;
  endtask

  task automatic tick();
    @(negedge sys_clk);
    observe();
  endtask

  // One full load followed by a swap. swap_at >= 0 raises swap_req while beat swap_at is offered.
  task automatic episode(input int gap_mode, input bit pat_data, input int swap_at, input bit stray_start);
    logic [7:0] sent     [PAGES];
    int         acc_edge [PAGES];
    int         n, budget, raise_edge, done_edge, es, bad, ready_bad, post_bad, waits;
    logic       old_roff;
    clear_sb();
    old_roff   = model_roff;
    n          = 0;
    budget     = 0;
    raise_edge = -1;
    ready_bad  = 0;
    post_bad   = 0;
    tick(); load_start = 1'b1;
    tick(); load_start = 1'b0;
    while (n < int'(PAGES) && budget < 1000) begin
      if (!ld_ready) ready_bad++;
      case (gap_mode)
        0:       ld_valid = 1'b1;
        1:       ld_valid = (budget % 2 == 0);
        default: ld_valid = ($urandom_range(99) < 60);
      endcase
      ld_data    = pat_data ? {n[3:0], ~n[3:0]} : 8'($urandom);
      load_start = stray_start && ($urandom_range(7) == 0);
      if (ld_valid) begin
        sent[n]     = ld_data;
        acc_edge[n] = cyc + 1;
        if (n == swap_at) begin
          swap_req   = 1'b1;
          raise_edge = cyc + 1;
        end
        n++;
      end
      tick();
      budget++;
    end
    ld_valid   = 1'b0;
    load_start = 1'b0;
    if (raise_edge < 0) begin
      waits = int'($urandom_range(3));
      for (int w = 0; w < waits; w++) begin
        if (ld_ready) post_bad++;
        tick();
      end
      if (ld_ready) post_bad++;
      swap_req   = 1'b1;
      load_start = stray_start;
      raise_edge = cyc + 1;
      tick();
      load_start = 1'b0;
    end
    budget = 0;
    while (ack_cnt == 0 && budget < 50) begin
      if (ld_ready) post_bad++;
      tick();
      budget++;
    end
    swap_req = 1'b0;
    for (int w = 0; w < 3; w++) begin
      if (ld_ready) post_bad++;
      tick();
    end

    done_edge = (n == int'(PAGES)) ? acc_edge[PAGES-1] : -1;
    es        = (raise_edge > done_edge + 1) ? raise_edge : done_edge + 1;
    bad       = 0;
    for (int i = 0; i < n; i++) begin
      if (mem_cap[!old_roff][i] != sent[i] || wr_cnt[i] != 1 || wr_cyc[i] != acc_edge[i]) bad++;
    end
    chk("ld_ready_during_load", ready_bad, 0);
    chk("page_data_mismatches", bad, 0);
    chk("we_pulses", we_total, int'(PAGES));
    chk("load_done_count", done_cnt, 1);
    chk("load_done_cycle", done_cyc, done_edge);
    chk("swap_ack_count", ack_cnt, 1);
    chk("swap_ack_cycle", ack_cyc, es + int'(PL) + 1);
    chk("rd_hold_cycles", hold_cnt, int'(PL) + 1);
    chk("read_offset_toggles", toggle_cnt, 1);
    chk("read_offset_toggle_cycle", toggle_cyc, es);
    chk("ld_ready_after_load", post_bad, 0);
    chk("protocol_violations", viol, 0);
    model_roff = !model_roff;
    chk("read_offset_after_swap", int'(read_addr_offset), int'(model_roff));
    chk("write_offset_after_swap", int'(write_addr_offset), int'(!model_roff));
  endtask

  // Reset in the middle of a load after a swap has moved the read half to 1.
  task automatic reset_mid_load();
    clear_sb();
    chk("pre_reset_read_offset", int'(read_addr_offset), int'(model_roff));
    tick(); load_start = 1'b1;
    tick(); load_start = 1'b0;
    for (int n = 0; n <= 30; n++) begin
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      tick();
    end
    chk("mid_load_we", int'(we), 1);
    chk("mid_load_page", int'(page_write_addr), 30);
    rst = 1'b1; ld_valid = 1'b1;
    tick();
    model_roff = 1'b0;
    chk("rst_we", int'(we), 0);
    chk("rst_read_offset", int'(read_addr_offset), 0);
    chk("rst_write_offset", int'(write_addr_offset), 1);
    chk("rst_ld_ready", int'(ld_ready), 0);
    chk("rst_page", int'(page_write_addr), 0);
    chk("rst_rd_hold", int'(rd_hold), 0);
    rst = 1'b0; ld_valid = 1'b0;
    tick(); tick();
    chk("idle_ld_ready", int'(ld_ready), 0);
    load_start = 1'b1;
    tick(); load_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h96;
    tick(); ld_valid = 1'b0;
    chk("restart_we", int'(we), 1);
    chk("restart_page", int'(page_write_addr), 0);
    chk("restart_bank0", int'(lut_in_bank0), 6);
    chk("restart_bank1", int'(lut_in_bank1), 9);
    rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
  endtask

  initial begin
    int gm, sa;
    bit st;
    rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0; swap_req = 1'b0;
    model_roff = 1'b0;
    prev_roff  = 1'b0;

    //          rst  ls   vld  swp  data    rdy  we   done ack  hold roff page  b0    b1
    vt[0] = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,4'h0,4'h0};
    vt[1] = '{1'b0,1'b0,1'b1,1'b1,8'hFF, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,4'h0,4'h0};
    vt[2] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,4'h0,4'h0};
    vt[3] = '{1'b0,1'b0,1'b1,1'b0,8'hA5, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,6'd0,4'h5,4'hA};
    vt[4] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,4'h5,4'hA};
    vt[5] = '{1'b0,1'b0,1'b1,1'b0,8'h3C, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,6'd1,4'hC,4'h3};
    vt[6] = '{1'b0,1'b1,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'd1,4'hC,4'h3};
    vt[7] = '{1'b0,1'b0,1'b1,1'b0,8'h7E, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,6'd2,4'hE,4'h7};
    vt[8] = '{1'b1,1'b0,1'b1,1'b0,8'h11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,4'h0,4'h0};
    vt[9] = '{1'b0,1'b0,1'b1,1'b1,8'h22, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,4'h0,4'h0};

    for (int i = 0; i < 10; i++) begin
      rst = vt[i].rst; load_start = vt[i].ls; ld_valid = vt[i].vld;
      swap_req = vt[i].swp; ld_data = vt[i].data;
      tick();
      chk($sformatf("vec%0d_ld_ready", i), int'(ld_ready), int'(vt[i].e_rdy));
      chk($sformatf("vec%0d_we", i), int'(we), int'(vt[i].e_we));
      chk($sformatf("vec%0d_load_done", i), int'(load_done), int'(vt[i].e_done));
      chk($sformatf("vec%0d_swap_ack", i), int'(swap_ack), int'(vt[i].e_ack));
      chk($sformatf("vec%0d_rd_hold", i), int'(rd_hold), int'(vt[i].e_hold));
      chk($sformatf("vec%0d_read_offset", i), int'(read_addr_offset), int'(vt[i].e_roff));
      chk($sformatf("vec%0d_write_offset", i), int'(write_addr_offset), int'(!vt[i].e_roff));
      chk($sformatf("vec%0d_page", i), int'(page_write_addr), int'(vt[i].e_page));
      chk($sformatf("vec%0d_bank0", i), int'(lut_in_bank0), int'(vt[i].e_b0));
      chk($sformatf("vec%0d_bank1", i), int'(lut_in_bank1), int'(vt[i].e_b1));
    end
    rst = 1'b0; load_start = 1'b0; ld_valid = 1'b0; swap_req = 1'b0; ld_data = '0;
    tick(); tick();

    episode(0, 1'b1, -1, 1'b0);   // back-to-back, patterned data, swap after load_done
    reset_mid_load();
    episode(1, 1'b0, -1, 1'b0);   // valid every other cycle
    episode(0, 1'b0, 10, 1'b0);   // swap requested during the load
    episode(2, 1'b0, -1, 1'b1);   // load_start together with swap_req in LOADED
    for (int e = 0; e < 8; e++) begin
      gm = int'($urandom_range(2));
      sa = ($urandom_range(1) == 1) ? int'($urandom_range(63)) : -1;
      st = 1'($urandom_range(1));
      episode(gm, 1'b0, sa, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
